// File: rtl/lut_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lut_cfg_loader                                                   |
// | Purpose  : Serial truth-table loader for one universal-gate cell. Bits     |
// |            arrive MSB-first over a valid/ready handshake, are assembled in |
// |            a shadow register, and the complete table is committed to the  |
// |            active table in a single edge. The mux tree therefore never     |
// |            sees a partially loaded table.                                  |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            cfg_valid       - cfg_data carries a table bit                  |
// |            cfg_data        - serial table bit, table[WIDTH-1] sent first   |
// |            cfg_ready       - a bit is accepted this cycle (combinational)  |
// |            cfg_abort       - drop the partial load in progress             |
// |            lut_table       - active truth table (named lut_table because   |
// |                              'table' is a reserved SystemVerilog word)     |
// |            loaded          - at least one table committed since reset      |
// |            commit          - one-cycle pulse, table updated at prior edge  |
// |            cfg_dout        - daisy-chain output, shadow MSB                |
// |                              (only with LUT_CFG_LOADER_CHAIN_EN defined)   |
// | Options  : LUT_CFG_LOADER_CHAIN_EN - adds cfg_dout for loader chaining     |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module lut_cfg_loader #(
  parameter int SEL_BITS = 4,
  parameter int WIDTH    = 2**SEL_BITS,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic             cfg_data,
  output logic             cfg_ready,
  input  logic             cfg_abort,
  output logic [WIDTH-1:0] lut_table,
  output logic             loaded,
  output logic             commit
`ifdef LUT_CFG_LOADER_CHAIN_EN
  ,
  output logic             cfg_dout
`endif
);

  localparam logic [0:0] ST_SHIFT  = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic             accept;

  assign cfg_ready = (state == ST_SHIFT) && !rst;

  // Abort has priority over a simultaneous valid bit: the bit is dropped.
  assign accept = cfg_valid && cfg_ready && !cfg_abort;

`ifdef LUT_CFG_LOADER_CHAIN_EN
  // The shadow MSB is the bit that leaves on the next accepted shift, so the
  // downstream loader samples it on that same edge.
  assign cfg_dout = shadow[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SHIFT;
      cnt       <= '0;
      shadow    <= '0;
      lut_table <= '0;
      loaded    <= 1'b0;
      commit    <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        ST_SHIFT: begin
          if (cfg_abort) begin
            cnt <= '0;
          end else if (accept) begin
            shadow <= {shadow[WIDTH-2:0], cfg_data};
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= ST_COMMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          // Abort is ignored here: the shadow is already complete.
          lut_table <= shadow;
          loaded    <= 1'b1;
          commit    <= 1'b1;
          state     <= ST_SHIFT;
        end
        default: begin
          state <= ST_SHIFT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lut_cfg_loader                                                |
// | Purpose  : Bench for lut_cfg_loader. The driver keeps a history of accepted|
// |            bits and, whenever a table completes, queues the expected table |
// |            and the cycle it must appear in; a negedge monitor compares.    |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_lut_cfg_loader;

  localparam int SEL_BITS = 4;
  localparam int WIDTH    = 2**SEL_BITS;
  localparam int CNT_W    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_data = 1'b0;
  logic             cfg_abort = 1'b0;
  logic             cfg_ready;
  logic [WIDTH-1:0] lut_table;
  logic             loaded;
  logic             commit;
`ifdef LUT_CFG_LOADER_CHAIN_EN
  logic             cfg_dout;
`endif

  lut_cfg_loader #(.SEL_BITS(SEL_BITS), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_abort (cfg_abort),
    .lut_table (lut_table),
    .loaded    (loaded),
    .commit    (commit)
`ifdef LUT_CFG_LOADER_CHAIN_EN
    ,
    .cfg_dout  (cfg_dout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  bit               hist[$];     // last WIDTH accepted bits, oldest first
  int               run;         // bits accepted in the current load
  bit               m_commit;    // a completed table is waiting to commit
  bit               exp_ready;
  bit               exp_dout;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  bit               mon_en = 0;
  bit               rst_last = 0;
  logic [WIDTH-1:0] mon_table = '0;
  bit               mon_loaded = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] hist_value();
    logic [WIDTH-1:0] r = '0;
    foreach (hist[i]) r = {r[WIDTH-2:0], hist[i]};
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus, plus the reference model's view of the next edge.
  task automatic cycle(bit v, bit d, bit a, bit r);
    logic [WIDTH-1:0] h;
    @(posedge clk);
    #1;
    cfg_valid = v;
    cfg_data  = d;
    cfg_abort = a;
    rst       = r;
    exp_ready = !r && !m_commit;
    h         = hist_value();
    exp_dout  = h[WIDTH-1];
    if (r) begin
      m_commit = 0;
      run      = 0;
      hist.delete();
      repeat (WIDTH) hist.push_back(1'b0);
    end else if (m_commit) begin
      sb.push_back('{h, cyc + 1});
      m_commit = 0;
    end else if (a) begin
      run = 0;
    end else if (v) begin
      hist.push_back(d);
      void'(hist.pop_front());
      run++;
      if (run == WIDTH) begin
        run      = 0;
        m_commit = 1;
      end
    end
  endtask

  // Sends the top n bits of val MSB-first; valid asserted with pct% chance.
  task automatic send_bits(logic [WIDTH-1:0] val, int n, int pct);
    int  i = WIDTH - 1;
    int  sent = 0;
    bit  v;
    bit  acc;
    while (sent < n) begin
      v   = ($urandom_range(99) < pct);
      acc = v && !m_commit;
      cycle(v, v ? val[i] : 1'($urandom_range(1)), 1'b0, 1'b0);
      if (acc) begin
        i--;
        sent++;
      end
    end
  endtask

  task automatic send_word(logic [WIDTH-1:0] val, int pct);
    send_bits(val, WIDTH, pct);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_last) begin
        mon_table  = '0;
        mon_loaded = 0;
      end
      check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("commit_pulse", 32'(commit), 32'd1);
        check("table_on_commit", 32'(lut_table), 32'(e.val));
        mon_table  = e.val;
        mon_loaded = 1;
      end else begin
        check("commit_idle", 32'(commit), 32'd0);
        check("table_stable", 32'(lut_table), 32'(mon_table));
      end
      check("loaded", 32'(loaded), 32'(mon_loaded));
`ifdef LUT_CFG_LOADER_CHAIN_EN
      check("cfg_dout", 32'(cfg_dout), 32'(exp_dout));
`endif
    end
    rst_last = rst;
  end

  initial begin
    m_commit  = 0;
    run       = 0;
    exp_ready = 0;
    exp_dout  = 0;
    repeat (WIDTH) hist.push_back(1'b0);

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    mon_en = 1;

    // Plain back-to-back load, then idle.
    send_word(16'hA5C3, 100);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Partial load discarded by abort (with valid high) before a new load.
    send_word(16'hFFFF, 100);
    send_bits(16'h5A5A, 7, 100);
    cycle(1, 1, 1, 0);
    send_word(16'h0001, 100);

    // Bursty valid.
    send_word(16'h1234, 50);

    // Reset in the middle of a load over an existing table.
    send_word(16'h00FF, 100);
    send_bits(16'h3C3C, 10, 100);
    cycle(0, 0, 0, 1);
    send_word(16'hBEEF, 100);

    // Abort during the commit cycle is ignored.
    send_word(16'h8001, 100);
    cycle(1, 1, 1, 0);

    // Reset during the commit cycle loses the pending commit.
    send_word(16'h7E7E, 100);
    cycle(0, 0, 0, 1);
    send_word(16'h4242, 100);

    // Randomised partial loads, aborts and bursty loads.
    repeat (6) begin
      send_bits(WIDTH'($urandom), int'($urandom_range(1, 15)), 80);
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'b0);
      send_word(WIDTH'($urandom), 70);
    end

    repeat (3) cycle(0, 0, 0, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
